// File: rtl/traffic_phase_ctrl.sv
// N-phase round-robin intersection controller with latched pedestrian walk
// interval and blinking-yellow fault mode; lamps are registered Moore outputs.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES    = 4,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int PED_CYCLES    = 5,
    parameter int BLINK_CYCLES  = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] req,
    input  logic                  ped_req,
    input  logic                  blink_en,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic                  walk,
    output logic [2:0]            phase,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        S_GREEN  = 3'd0,
        S_YELLOW = 3'd1,
        S_ALLRED = 3'd2,
        S_WALK   = 3'd3,
        S_BLINK  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LD  = CNT_W'(BLINK_CYCLES - 1);

    state_t                r_state, w_state_next;
    logic [2:0]            r_phase, w_phase_next, w_sel;
    logic [CNT_W-1:0]      r_timer, w_timer_next;
    logic [NUM_PHASES-1:0] r_pending, w_pending_next, w_req_masked, w_others;
    logic                  r_ped, w_ped_next, w_ped_clear;
    logic                  r_tog, w_tog_next;
    logic                  w_green_entry;
    logic [NUM_PHASES-1:0] r_green, r_yellow, r_red;
    logic [NUM_PHASES-1:0] w_green_next, w_yellow_next, w_red_next;
    logic                  r_walk;

    // Per-phase request latching and lamp decode of the upcoming state.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
            assign w_req_masked[gi]   = req[gi] & ~((r_state == S_GREEN) && (r_phase == 3'(gi)));
            assign w_others[gi]       = (r_pending[gi] | req[gi]) & (r_phase != 3'(gi));
            assign w_pending_next[gi] = (r_pending[gi] | w_req_masked[gi])
                                        & ~(w_green_entry && (w_phase_next == 3'(gi)));
            assign w_green_next[gi]   = (w_state_next == S_GREEN) && (w_phase_next == 3'(gi));
            assign w_yellow_next[gi]  = ((w_state_next == S_YELLOW) && (w_phase_next == 3'(gi)))
                                        || ((w_state_next == S_BLINK) && w_tog_next);
            assign w_red_next[gi]     = (((w_state_next == S_GREEN) || (w_state_next == S_YELLOW))
                                         && (w_phase_next != 3'(gi)))
                                        || (w_state_next == S_ALLRED) || (w_state_next == S_WALK);
        end
    endgenerate

    // Round-robin pick: nearest pending phase after the current one, else stay.
    always_comb begin
        w_sel = r_phase;
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (r_pending[i] && (((int'(r_phase) + k) % NUM_PHASES) == i)) begin
                    w_sel = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_phase_next  = r_phase;
        w_timer_next  = r_timer;
        w_tog_next    = r_tog;
        w_green_entry = 1'b0;
        w_ped_clear   = 1'b0;
        if (blink_en) begin
            if (r_state != S_BLINK) begin
                w_state_next = S_BLINK;
                w_timer_next = BLINK_LD;
                w_tog_next   = 1'b1;
            end else if (r_timer == '0) begin
                w_timer_next = BLINK_LD;
                w_tog_next   = ~r_tog;
            end else begin
                w_timer_next = r_timer - 1'b1;
            end
        end else begin
            case (r_state)
                S_GREEN: begin
                    if (r_timer != '0) begin
                        w_timer_next = r_timer - 1'b1;
                    end else if ((|w_others) || r_ped || ped_req) begin
                        w_state_next = S_YELLOW;
                        w_timer_next = YELLOW_LD;
                    end
                end
                S_YELLOW: begin
                    if (r_timer != '0) begin
                        w_timer_next = r_timer - 1'b1;
                    end else begin
                        w_state_next = S_ALLRED;
                        w_timer_next = ALLRED_LD;
                    end
                end
                S_ALLRED: begin
                    if (r_timer != '0) begin
                        w_timer_next = r_timer - 1'b1;
                    end else if (r_ped) begin
                        w_state_next = S_WALK;
                        w_timer_next = PED_LD;
                        w_ped_clear  = 1'b1;
                    end else begin
                        w_state_next  = S_GREEN;
                        w_phase_next  = w_sel;
                        w_timer_next  = GREEN_LD;
                        w_green_entry = 1'b1;
                    end
                end
                S_WALK: begin
                    if (r_timer != '0) begin
                        w_timer_next = r_timer - 1'b1;
                    end else begin
                        w_state_next  = S_GREEN;
                        w_phase_next  = w_sel;
                        w_timer_next  = GREEN_LD;
                        w_green_entry = 1'b1;
                    end
                end
                S_BLINK: begin
                    w_state_next = S_ALLRED;
                    w_timer_next = ALLRED_LD;
                end
                default: begin
                    w_state_next = S_GREEN;
                    w_timer_next = GREEN_LD;
                end
            endcase
        end
        w_ped_next = (r_ped | ped_req) & ~w_ped_clear;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_GREEN;
            r_phase   <= 3'd0;
            r_timer   <= GREEN_LD;
            r_pending <= '0;
            r_ped     <= 1'b0;
            r_tog     <= 1'b0;
            r_green   <= NUM_PHASES'(1);
            r_yellow  <= '0;
            r_red     <= ~NUM_PHASES'(1);
            r_walk    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_timer   <= w_timer_next;
            r_pending <= w_pending_next;
            r_ped     <= w_ped_next;
            r_tog     <= w_tog_next;
            r_green   <= w_green_next;
            r_yellow  <= w_yellow_next;
            r_red     <= w_red_next;
            r_walk    <= (w_state_next == S_WALK);
        end
    end

    assign green   = r_green;
    assign yellow  = r_yellow;
    assign red     = r_red;
    assign walk    = r_walk;
    assign phase   = r_phase;
    assign state_o = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against a dwell-counting model.
module tb_traffic_phase_ctrl;

    localparam int NP = 4;
    localparam int GC = 8;
    localparam int YC = 3;
    localparam int AC = 2;
    localparam int PC = 5;
    localparam int BC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NP-1:0] req = '0;
    logic          ped_req = 1'b0;
    logic          blink_en = 1'b0;
    logic [NP-1:0] green, yellow, red;
    logic          walk;
    logic [2:0]    phase, state_o;

    int total = 0;
    int bad   = 0;

    traffic_phase_ctrl #(
        .NUM_PHASES(NP), .GREEN_CYCLES(GC), .YELLOW_CYCLES(YC),
        .ALLRED_CYCLES(AC), .PED_CYCLES(PC), .BLINK_CYCLES(BC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .ped_req(ped_req), .blink_en(blink_en),
        .green(green), .yellow(yellow), .red(red), .walk(walk),
        .phase(phase), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Model: mode uses the published state_o codes, el = cycles already spent in mode.
    typedef struct {
        int       mode;
        int       ph;
        int       el;
        bit [3:0] pend;
        bit       ped;
    } mstate_t;

    mstate_t m;

    function automatic int dwell(int mode);
        case (mode)
            0: return GC;
            1: return YC;
            2: return AC;
            3: return PC;
            default: return BC;
        endcase
    endfunction

    function automatic mstate_t enter_green(mstate_t s, mstate_t n);
        int  nxt   = s.ph;
        bit  found = 0;
        for (int k = 1; k < NP; k++) begin
            int j = (s.ph + k) % NP;
            if (!found && s.pend[j]) begin
                nxt   = j;
                found = 1;
            end
        end
        n.mode = 0;
        n.ph = nxt;
        n.el = 0;
        n.pend[nxt] = 0;
        return n;
    endfunction

    function automatic mstate_t next_state(mstate_t s, bit [3:0] r, bit p, bit b);
        mstate_t n = s;
        bit last = (s.el >= dwell(s.mode) - 1);
        bit others = 0;
        for (int i = 0; i < NP; i++) begin
            if (r[i] && !(s.mode == 0 && s.ph == i)) n.pend[i] = 1;
            if ((s.pend[i] || r[i]) && i != s.ph) others = 1;
        end
        if (p) n.ped = 1;
        if (b) begin
            if (s.mode != 4) begin n.mode = 4; n.el = 0; end
            else n.el = s.el + 1;
            return n;
        end
        case (s.mode)
            0: begin
                if (last && (others || s.ped || p)) begin n.mode = 1; n.el = 0; end
                else n.el = s.el + 1;
            end
            1: begin
                if (last) begin n.mode = 2; n.el = 0; end
                else n.el = s.el + 1;
            end
            2: begin
                if (!last) n.el = s.el + 1;
                else if (s.ped) begin n.mode = 3; n.el = 0; n.ped = 0; end
                else n = enter_green(s, n);
            end
            3: begin
                if (!last) n.el = s.el + 1;
                else n = enter_green(s, n);
            end
            default: begin n.mode = 2; n.el = 0; end
        endcase
        return n;
    endfunction

    function automatic logic [18:0] expect_out(mstate_t s);
        logic [3:0] g = '0, y = '0, r = '0;
        for (int i = 0; i < NP; i++) begin
            g[i] = (s.mode == 0 && s.ph == i);
            y[i] = (s.mode == 1 && s.ph == i) || (s.mode == 4 && ((s.el / BC) % 2 == 0));
            r[i] = ((s.mode <= 1) && s.ph != i) || s.mode == 2 || s.mode == 3;
        end
        return {g, y, r, s.mode == 3, 3'(s.ph), 3'(s.mode)};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m.mode = 0; m.ph = 0; m.el = 0; m.pend = '0; m.ped = 0;
            end else begin
                m = next_state(m, req, ped_req, blink_en);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        logic [18:0] act, exp_v;
        forever begin
            @(negedge clk);
            act   = {green, yellow, red, walk, phase, state_o};
            exp_v = expect_out(m);
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL model t=%0t got g=%b y=%b r=%b w=%b ph=%0d st=%0d want g=%b y=%b r=%b w=%b ph=%0d st=%0d",
                         $time, act[18:15], act[14:11], act[10:7], act[6], act[5:3], act[2:0],
                         exp_v[18:15], exp_v[14:11], exp_v[10:7], exp_v[6], exp_v[5:3], exp_v[2:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; ped_req = 1'b0; blink_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Idle: phase 0 keeps green indefinitely.
        do_reset();
        for (int n = 0; n < 50; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            chk("idle", 32'({green, state_o, walk}), 32'({4'b0001, 3'd0, 1'b0}));
        end

        // Single request pulse for phase 2.
        do_reset();
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (n == 7)  chk("pulse_g0_end", 32'(green), 32'b0001);
            if (n == 8)  chk("pulse_y_start", 32'({green, yellow}), 32'({4'b0000, 4'b0001}));
            if (n == 10) chk("pulse_y_end", 32'(yellow), 32'b0001);
            if (n == 11) chk("pulse_allred", 32'({red, state_o}), 32'({4'b1111, 3'd2}));
            if (n == 12) chk("pulse_allred2", 32'(state_o), 32'd2);
            if (n == 13) chk("pulse_g2", 32'({green, phase}), 32'({4'b0100, 3'd2}));
            if (n == 20) chk("pulse_hold", 32'({green, state_o}), 32'({4'b0100, 3'd0}));
            req = (n == 2) ? 4'b0100 : 4'b0000;
        end

        // Held requests on phases 1 and 3: round robin 0,1,3,1,3.
        do_reset();
        req = 4'b1010;
        for (int n = 0; n <= 59; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (n == 12) chk("rr_pre1", 32'(green), 32'b0000);
            if (n == 13) chk("rr_g1", 32'({green, phase}), 32'({4'b0010, 3'd1}));
            if (n == 20) chk("rr_g1_end", 32'(green), 32'b0010);
            if (n == 21) chk("rr_y1", 32'(yellow), 32'b0010);
            if (n == 26) chk("rr_g3", 32'({green, phase}), 32'({4'b1000, 3'd3}));
            if (n == 33) chk("rr_g3_end", 32'(green), 32'b1000);
            if (n == 39) chk("rr_g1b", 32'(green), 32'b0010);
            if (n == 52) chk("rr_g3b", 32'(green), 32'b1000);
        end

        // Pedestrian walk, plus a second press during the walk.
        do_reset();
        req = 4'b0010;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (n == 12) chk("ped_allred", 32'({red, walk}), 32'({4'b1111, 1'b0}));
            if (n == 13) chk("ped_walk_on", 32'({walk, state_o}), 32'({1'b1, 3'd3}));
            if (n == 17) chk("ped_walk_end", 32'(walk), 32'd1);
            if (n == 18) chk("ped_g1", 32'({walk, green}), 32'({1'b0, 4'b0010}));
            if (n == 26) chk("ped2_yellow", 32'(yellow), 32'b0010);
            if (n == 31) chk("ped2_walk_on", 32'(walk), 32'd1);
            if (n == 35) chk("ped2_walk_end", 32'(walk), 32'd1);
            if (n == 36) chk("ped2_g1", 32'({walk, green}), 32'({1'b0, 4'b0010}));
            if (n == 40) chk("ped2_hold", 32'({green, state_o}), 32'({4'b0010, 3'd0}));
            ped_req = (n == 3 || n == 15);
        end

        // Blink entered from yellow, then released.
        do_reset();
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (n == 10) chk("blink_on", 32'({green, red, yellow}), 32'({4'b0000, 4'b0000, 4'b1111}));
            if (n == 13) chk("blink_on_end", 32'(yellow), 32'b1111);
            if (n == 14) chk("blink_off", 32'({yellow, red, walk}), 32'({4'b0000, 4'b0000, 1'b0}));
            if (n == 17) chk("blink_off_end", 32'(yellow), 32'b0000);
            if (n == 18) chk("blink_on2", 32'(yellow), 32'b1111);
            if (n == 20) chk("blink_exit_ar", 32'({red, state_o}), 32'({4'b1111, 3'd2}));
            if (n == 21) chk("blink_exit_ar2", 32'(state_o), 32'd2);
            if (n == 22) chk("blink_exit_g", 32'({green, phase}), 32'({4'b0100, 3'd2}));
            req = (n == 2) ? 4'b0100 : 4'b0000;
            blink_en = (n >= 9 && n <= 18);
        end

        // Asynchronous reset in the middle of a walk.
        do_reset();
        for (int n = 0; n <= 15; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            ped_req = (n == 3 || n == 14);
        end
        chk("rst_pre_walk", 32'(walk), 32'd1);
        ped_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async", 32'({walk, green, phase, state_o}), 32'({1'b0, 4'b0001, 3'd0, 3'd0}));
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n <= 10; n++) begin
            if (n > 0) @(negedge clk);
            #1;
        end
        chk("rst_ped_cleared", 32'({green, state_o}), 32'({4'b0001, 3'd0}));

        // Random traffic, checked by the per-cycle model comparison.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (!rst) rst = 1'b1;
            for (int i = 0; i < NP; i++) req[i] = ($urandom_range(15) == 0);
            ped_req = ($urandom_range(39) == 0);
            if ($urandom_range(79) == 0) blink_en = ~blink_en;
            if ($urandom_range(999) == 0) rst = 1'b0;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-phase intersection controller; successor to the two-road lab8 controller. It handles NUM_PHASES vehicle phases, a latched pedestrian walk interval and a blinking-yellow fault mode. Phases are served round-robin, and every dwell time is set by a parameter. The block drives the lamp outputs directly and exposes its current phase and state for the display/debug logic.

## Interface
- NUM_PHASES, 4: number of vehicle phases, 2..8
- GREEN_CYCLES, 8: minimum green dwell in clk cycles, ≥1
- YELLOW_CYCLES, 3: yellow dwell, ≥1
- ALLRED_CYCLES, 2: all-red clearance dwell, ≥1
- PED_CYCLES, 5: walk dwell, ≥1
- BLINK_CYCLES, 4: half-period of blink toggle, ≥1
- CNT_W, 8: timer width; must hold max(all dwell parameters)-1
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_PHASES  vehicle sensor per phase, level, synchronous
- ped_req  in  1  pedestrian button, level or pulse
- blink_en  in  1  fault/maintenance blink request, level
- green  out  NUM_PHASES  green lamp per phase
- yellow  out  NUM_PHASES  yellow lamp per phase
- red  out  NUM_PHASES  red lamp per phase
- walk  out  1  pedestrian walk lamp
- phase  out  3  index of the phase currently owning the intersection
- state_o  out  3  encoded state: GREEN=0, YELLOW=1, ALLRED=2, WALK=3, BLINK=4

## Operation
- States: GREEN, YELLOW, ALLRED, WALK, BLINK. Outputs are a Moore function of state and phase only.
- GREEN: green[phase]=1; red=1 on all other phases.
- YELLOW: yellow[phase]=1; red=1 on all other phases.
- ALLRED and WALK: red all 1. walk=1 only in WALK.
- BLINK: green=0, red=0, walk=0. yellow is all 1s or all 0s, toggling every BLINK_CYCLES.
- Timer: loaded with DWELL-1 on state entry and decrements to 0. Each state lasts exactly DWELL cycles unless held (GREEN) or preempted (BLINK).
- Request latching:
  - pending[i] is set on any cycle with req[i]=1, except for i==phase while in GREEN.
  - ped_pending is set on any cycle with ped_req=1.
  - Both are cleared only as described below and at reset.
- GREEN with timer==0:
  - If (pending|req) has any bit other than phase, or ped_pending|ped_req is set: go to YELLOW.
  - Otherwise hold GREEN indefinitely, timer stays 0.
- YELLOW with timer==0: go to ALLRED.
- ALLRED with timer==0:
  - If ped_pending: go to WALK and clear ped_pending.
  - Otherwise go to GREEN of next phase.
- WALK with timer==0: go to GREEN of next phase.
- Next phase: first index with pending=1, searched circularly from phase+1. If none, the same phase. On GREEN entry, pending[next] is cleared.
- BLINK:
  - blink_en=1 forces BLINK on the next edge from any state. The timer is reloaded, the yellow toggle starts at 1, and phase is unchanged.
  - While in BLINK, pending and ped_pending continue latching.
  - blink_en=0 while in BLINK: go to ALLRED (full clearance), then follow normal selection.
- Priority per edge: reset > blink_en > timer expiry > hold.
- Reset values: state=GREEN, phase=0, timer=GREEN_CYCLES-1, pending=0, ped_pending=0.
  - Outputs at reset: green=0…01, yellow=0, red=1…10, walk=0, state_o=0.
- Reset mid-cycle is asynchronous. It overrides every state, including BLINK and WALK.

## Timing
- Single clock. All state, timer and latch registers update on posedge clk.
- Decision latency: a req or ped_req sampled on a cycle where GREEN timer==0 produces YELLOW on the following cycle (one edge). No prior latching is required.
- A full changeover without pedestrian takes YELLOW_CYCLES + ALLRED_CYCLES cycles between the last green cycle of phase A and the first green cycle of phase B.
- With pedestrian, PED_CYCLES is added.
- Never more than one green bit is set. No cycle has green and yellow set on the same phase.
- blink_en to yellow-all-on: 1 edge. blink_en drop to first non-blink output: 1 edge, into ALLRED.

## Test plan
All scenarios use defaults.
- Reset, no requests for 50 cycles: green=0001 for the whole run, state_o=0, walk=0.
- req=0100 pulsed for 1 cycle at cycle 2:
  - green[0] held through cycle 7, yellow[0] for 3 cycles, all-red for 2 cycles.
  - green=0100 from cycle 13; pending[2] is cleared.
- req=1010 held from reset: phases serve in order 0→1→3→1→3 round-robin, each green lasting exactly 8 cycles.
- ped_req pulse during GREEN phase 0 with req=0010:
  - YELLOW, ALLRED, then walk=1 for exactly 5 cycles, then green=0010.
  - A second ped_req during WALK causes a second walk on the next changeover.
- blink_en raised during YELLOW:
  - Next cycle has green=0, red=0, yellow=1111 for 4 cycles, then 0000 for 4 cycles.
  - On blink_en low: 2 cycles all-red, then GREEN per pending.
- rst asserted during WALK: walk=0, green=0001 and phase=0 immediately; ped_pending is cleared.
